alu_op_sequencer: RTL and testbench

- Initiator side of the accumulator/ALU operand interface.
- Buffers operation commands `{m, a, b, cin}` in a small FIFO and issues them one at a time on the ALU operand bus.
- Waits a fixed ALU latency, captures `r`/`of`, and returns each result through a valid/ready handshake.
- Sits between a command source (CPU/test controller) and the 4-bit accumulator datapath; keeps a saturating overflow-event count.

---
 rtl/alu_op_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Purpose: buffers ALU commands and issues them one at a time on the operand bus, returning each result.
// Latency: push to op_valid is 1 edge; op_valid to res_valid is LATENCY edges; one idle edge between results.
// Backpressure: cmd_ready drops while the FIFO is full; res_* hold stable until res_ready.

// Generic synchronous FIFO; occupancy count exported so the owner derives its own ready.
module alu_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdat,
    output logic [WIDTH-1:0]         rdat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the owner misbehaves.
    assign do_push = push && (count != FULL);
    assign do_pop  = pop && (count != '0);
    assign rdat    = mem[rd_ptr];

    // Storage has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdat;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module alu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_m,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_cin,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic       op_cin,
    output logic [3:0] op_m,
    output logic       op_valid,
    input  logic [3:0] alu_r,
    input  logic       alu_of,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_r,
    output logic       res_of,
    output logic [3:0] res_m,
    output logic       res_err,
    output logic       busy,
    output logic [7:0] of_count
);
    typedef struct packed {
        logic [3:0] m;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESULT} state_t;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    cmd_t          wr_cmd;
    cmd_t          head;
    logic [CW-1:0] fifo_count;
    logic          push;
    logic          pop;
    state_t        state;
    logic [3:0]    wait_cnt;

    assign wr_cmd.m   = cmd_m;
    assign wr_cmd.a   = cmd_a;
    assign wr_cmd.b   = cmd_b;
    assign wr_cmd.cin = cmd_cin;

    // Ready comes from the pre-edge count, so a pop in the same edge never frees a slot early.
    assign cmd_ready = !Reset && (fifo_count < FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (fifo_count != '0);
    assign busy      = (state != IDLE) || (fifo_count != '0);

    alu_seq_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Reset),
        .push  (push),
        .pop   (pop),
        .wdat  (wr_cmd),
        .rdat  (head),
        .count (fifo_count)
    );

    // Issue / wait / hand-off FSM with registered operand and result outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            op_m      <= '0;
            op_valid  <= 1'b0;
            res_valid <= 1'b0;
            res_r     <= '0;
            res_of    <= 1'b0;
            res_m     <= '0;
            res_err   <= 1'b0;
            of_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_count != '0) begin
                        if (head.m[3]) begin
                            // Reserved opcode: report an error without touching the ALU bus.
                            res_err   <= 1'b1;
                            res_r     <= '0;
                            res_of    <= 1'b0;
                            res_m     <= head.m;
                            res_valid <= 1'b1;
                            state     <= RESULT;
                        end else begin
                            op_a     <= head.a;
                            op_b     <= head.b;
                            op_cin   <= head.cin;
                            op_m     <= head.m;
                            op_valid <= 1'b1;
                            wait_cnt <= 4'(LATENCY);
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        res_r     <= alu_r;
                        res_of    <= alu_of;
                        res_m     <= op_m;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        op_valid  <= 1'b0;
                        state     <= RESULT;
                        if (alu_of && (of_count != 8'hFF)) begin
                            of_count <= of_count + 8'd1;
                        end
                    end
                    wait_cnt <= wait_cnt - 4'd1;
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    logic       clk;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_cin;
    logic [3:0] cmd_m, cmd_a, cmd_b;
    logic [3:0] op_a, op_b, op_m;
    logic       op_cin, op_valid;
    logic [3:0] alu_r;
    logic       alu_of;
    logic       res_valid, res_ready, res_of, res_err, busy;
    logic [3:0] res_r, res_m;
    logic [7:0] of_count;

    // LATENCY=3 instance
    logic       rst3;
    logic       l3_cmd_valid, l3_cmd_ready, l3_cmd_cin;
    logic [3:0] l3_cmd_m, l3_cmd_a, l3_cmd_b;
    logic [3:0] l3_op_a, l3_op_b, l3_op_m;
    logic       l3_op_cin, l3_op_valid;
    logic [3:0] l3_alu_r;
    logic       l3_alu_of;
    logic       l3_res_valid, l3_res_ready, l3_res_of, l3_res_err, l3_busy;
    logic [3:0] l3_res_r, l3_res_m;
    logic [7:0] l3_of_count;
    logic [3:0] cyc;

    int tests;
    int fails;

    alu_op_sequencer #(.DEPTH(4), .LATENCY(1)) dut (
        .Clk(clk), .Reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_m(cmd_m), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_m(op_m), .op_valid(op_valid),
        .alu_r(alu_r), .alu_of(alu_of), .res_valid(res_valid), .res_ready(res_ready),
        .res_r(res_r), .res_of(res_of), .res_m(res_m), .res_err(res_err),
        .busy(busy), .of_count(of_count)
    );

    alu_op_sequencer #(.DEPTH(4), .LATENCY(3)) dut3 (
        .Clk(clk), .Reset(rst3), .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready),
        .cmd_m(l3_cmd_m), .cmd_a(l3_cmd_a), .cmd_b(l3_cmd_b), .cmd_cin(l3_cmd_cin),
        .op_a(l3_op_a), .op_b(l3_op_b), .op_cin(l3_op_cin), .op_m(l3_op_m), .op_valid(l3_op_valid),
        .alu_r(l3_alu_r), .alu_of(l3_alu_of), .res_valid(l3_res_valid), .res_ready(l3_res_ready),
        .res_r(l3_res_r), .res_of(l3_res_of), .res_m(l3_res_m), .res_err(l3_res_err),
        .busy(l3_busy), .of_count(l3_of_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter feeds the latency-3 ALU so its result changes every cycle.
    always @(posedge clk) cyc <= cyc + 4'd1;
    assign l3_alu_r  = cyc;
    assign l3_alu_of = 1'b0;

    // Behavioural ALU with one-edge latency: output is a function of the registered op bus.
    function automatic logic [4:0] alu_model(input logic [3:0] m, input logic [3:0] a,
                                             input logic [3:0] b, input logic cin);
        case (m)
            4'd0:    return {1'b0, a} + {1'b0, b} + {4'b0, cin};
            4'd1:    return {1'b0, a} - {1'b0, b} - {4'b0, cin};
            4'd2:    return {1'b0, a} - {1'b0, b};
            4'd3:    return {1'b0, a & b};
            4'd4:    return {1'b0, a | b};
            4'd5:    return {1'b0, ~a};
            4'd6:    return {1'b0, a} + 5'd1;
            4'd7:    return {1'b0, a} - 5'd1;
            default: return 5'd0;
        endcase
    endfunction
    assign {alu_of, alu_r} = alu_model(op_m, op_a, op_b, op_cin);

    task automatic drive_cmd(input logic [3:0] m, input logic [3:0] a, input logic [3:0] b, input logic cin);
        cmd_m = m; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
        tests++; if (op_valid !== 1'b0 || res_valid !== 1'b0) begin fails++; $display("FAIL reset_valids op=%b res=%b exp=0", op_valid, res_valid); end
        tests++; if (busy !== 1'b0 || of_count !== 8'd0) begin fails++; $display("FAIL reset_busy_count busy=%b cnt=%0d exp=0", busy, of_count); end
        tests++; if ({op_a, op_b, op_m, op_cin} !== 13'd0 || {res_r, res_m, res_of, res_err} !== 10'd0) begin fails++; $display("FAIL reset_data got op=%h res=%h exp=0", {op_a, op_b, op_m, op_cin}, {res_r, res_m, res_of, res_err}); end
        rst = 1'b0;
        #1;
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready); end
        @(negedge clk);
    endtask

    task automatic test_single_add();
        res_ready = 1'b0;
        drive_cmd(4'h0, 4'hF, 4'h1, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++; if (op_valid !== 1'b0) begin fails++; $display("FAIL add_op_early got=%b exp=0", op_valid); end
        @(negedge clk);
        tests++; if (op_valid !== 1'b1 || op_a !== 4'hF || op_b !== 4'h1 || op_m !== 4'h0 || op_cin !== 1'b0) begin fails++; $display("FAIL add_op_bus got v=%b a=%h b=%h m=%h c=%b exp v=1 a=f b=1 m=0 c=0", op_valid, op_a, op_b, op_m, op_cin); end
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL add_res_early got=%b exp=0", res_valid); end
        @(negedge clk);
        tests++; if (op_valid !== 1'b0) begin fails++; $display("FAIL add_op_one_cycle got=%b exp=0", op_valid); end
        tests++; if (res_valid !== 1'b1 || res_r !== 4'h0 || res_of !== 1'b1 || res_m !== 4'h0 || res_err !== 1'b0) begin fails++; $display("FAIL add_result got v=%b r=%h of=%b m=%h err=%b exp v=1 r=0 of=1 m=0 err=0", res_valid, res_r, res_of, res_m, res_err); end
        tests++; if (of_count !== 8'd1) begin fails++; $display("FAIL add_of_count got=%0d exp=1", of_count); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL add_release got v=%b busy=%b exp 0 0", res_valid, busy); end
    endtask

    task automatic test_backpressure();
        logic [3:0] cm [6] = '{4'h1, 4'h1, 4'h1, 4'h3, 4'h4, 4'h6};
        logic [3:0] ca [6] = '{4'hF, 4'hA, 4'h7, 4'hC, 4'hC, 4'h7};
        logic [3:0] cb [6] = '{4'h9, 4'h5, 4'hC, 4'hA, 4'h3, 4'h0};
        logic [3:0] er [5] = '{4'h6, 4'h5, 4'hB, 4'h8, 4'hF};
        logic       eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       rdy [6];
        int acc;
        int t;
        res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive_cmd(cm[i], ca[i], cb[i], 1'b0);
            #1 rdy[i] = cmd_ready;
            if (cmd_ready) acc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        tests++; if (acc != 5) begin fails++; $display("FAIL bp_accepted got=%0d exp=5", acc); end
        tests++; if (rdy[5] !== 1'b0) begin fails++; $display("FAIL bp_sixth_ready got=%b exp=0", rdy[5]); end
        for (int k = 0; k < 5; k++) begin
            t = 0;
            while (res_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
            tests++; if (t >= 20) begin fails++; $display("FAIL bp_timeout result %0d not seen within 20 cycles", k); end
            tests++; if (res_m !== cm[k] || res_r !== er[k] || res_of !== eo[k] || res_err !== 1'b0) begin fails++; $display("FAIL bp_result%0d got m=%h r=%h of=%b err=%b exp m=%h r=%h of=%b err=0", k, res_m, res_r, res_of, res_err, cm[k], er[k], eo[k]); end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        @(negedge clk);
        tests++; if (busy !== 1'b0 || res_valid !== 1'b0) begin fails++; $display("FAIL bp_drained got busy=%b v=%b exp 0 0", busy, res_valid); end
        tests++; if (of_count !== 8'd2) begin fails++; $display("FAIL bp_of_count got=%0d exp=2", of_count); end
    endtask

    task automatic test_reserved();
        int t;
        logic seen_op;
        res_ready = 1'b0;
        drive_cmd(4'h8, 4'hA, 4'h5, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++; if (res_valid !== 1'b0 || op_valid !== 1'b0) begin fails++; $display("FAIL rsv_early got v=%b op=%b exp 0 0", res_valid, op_valid); end
        @(negedge clk);
        tests++; if (op_valid !== 1'b0) begin fails++; $display("FAIL rsv_op_valid got=%b exp=0", op_valid); end
        tests++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_r !== 4'h0 || res_of !== 1'b0 || res_m !== 4'h8) begin fails++; $display("FAIL rsv_result got v=%b err=%b r=%h of=%b m=%h exp v=1 err=1 r=0 of=0 m=8", res_valid, res_err, res_r, res_of, res_m); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        drive_cmd(4'h3, 4'hC, 4'hA, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        seen_op = 1'b0;
        while (res_valid !== 1'b1 && t < 20) begin @(negedge clk); if (op_valid) seen_op = 1'b1; t++; end
        tests++; if (t >= 20 || seen_op !== 1'b1) begin fails++; $display("FAIL rsv_follow_issue t=%0d op_seen=%b exp result and op_valid", t, seen_op); end
        tests++; if (res_err !== 1'b0 || res_r !== 4'h8 || res_m !== 4'h3) begin fails++; $display("FAIL rsv_follow_result got err=%b r=%h m=%h exp err=0 r=8 m=3", res_err, res_r, res_m); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_latency();
        int t;
        logic [3:0] c0;
        logic [3:0] exp_r;
        rst3 = 1'b0;
        @(negedge clk);
        l3_cmd_m = 4'h3; l3_cmd_a = 4'hF; l3_cmd_b = 4'hF; l3_cmd_cin = 1'b0; l3_cmd_valid = 1'b1;
        @(negedge clk);
        l3_cmd_valid = 1'b0;
        t = 0;
        while (l3_op_valid !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        tests++; if (t >= 10) begin fails++; $display("FAIL lat_op_timeout op_valid not seen within 10 cycles"); end
        c0 = cyc;
        exp_r = c0 + 4'd2;
        @(negedge clk);
        tests++; if (l3_res_valid !== 1'b0 || l3_op_valid !== 1'b1) begin fails++; $display("FAIL lat_edge1 got res=%b op=%b exp 0 1", l3_res_valid, l3_op_valid); end
        @(negedge clk);
        tests++; if (l3_res_valid !== 1'b0 || l3_op_valid !== 1'b1) begin fails++; $display("FAIL lat_edge2 got res=%b op=%b exp 0 1", l3_res_valid, l3_op_valid); end
        @(negedge clk);
        tests++; if (l3_res_valid !== 1'b1 || l3_op_valid !== 1'b0) begin fails++; $display("FAIL lat_edge3 got res=%b op=%b exp 1 0", l3_res_valid, l3_op_valid); end
        tests++; if (l3_res_r !== exp_r || l3_res_m !== 4'h3) begin fails++; $display("FAIL lat_capture got r=%h m=%h exp r=%h m=3", l3_res_r, l3_res_m, exp_r); end
    endtask

    task automatic test_reset_mid();
        int t;
        logic stale;
        res_ready = 1'b0;
        drive_cmd(4'h0, 4'h1, 4'h1, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (res_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        tests++; if (t >= 20) begin fails++; $display("FAIL rm_setup_timeout first result not seen"); end
        for (int i = 0; i < 3; i++) begin
            drive_cmd(4'h0, 4'(i + 2), 4'h2, 1'b0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        @(negedge clk);
        tests++; if (op_valid !== 1'b1 || op_a !== 4'h2) begin fails++; $display("FAIL rm_in_wait got op=%b a=%h exp 1 2", op_valid, op_a); end
        rst = 1'b1;
        #1;
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rm_ready_in_reset got=%b exp=0", cmd_ready); end
        @(negedge clk);
        tests++; if (op_valid !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 || of_count !== 8'd0) begin fails++; $display("FAIL rm_cleared got op=%b res=%b busy=%b cnt=%0d exp 0", op_valid, res_valid, busy, of_count); end
        tests++; if ({op_a, op_b, op_m, op_cin} !== 13'd0 || {res_r, res_m, res_of, res_err} !== 10'd0) begin fails++; $display("FAIL rm_data got op=%h res=%h exp=0", {op_a, op_b, op_m, op_cin}, {res_r, res_m, res_of, res_err}); end
        rst = 1'b0;
        @(negedge clk);
        tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rm_after got ready=%b busy=%b exp 1 0", cmd_ready, busy); end
        res_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (op_valid || res_valid) stale = 1'b1;
        end
        res_ready = 1'b0;
        tests++; if (stale !== 1'b0) begin fails++; $display("FAIL rm_stale got activity=%b exp=0", stale); end
    endtask

    task automatic test_saturation();
        int n;
        int guard;
        res_ready = 1'b1;
        drive_cmd(4'h0, 4'hF, 4'h1, 1'b0);
        n = 0;
        guard = 0;
        while (n < 260 && guard < 5000) begin
            if (cmd_ready) n++;
            @(negedge clk);
            guard++;
            if (n == 260) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        tests++; if (n != 260) begin fails++; $display("FAIL sat_push got=%0d exp=260", n); end
        guard = 0;
        while (busy !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
        tests++; if (guard >= 100) begin fails++; $display("FAIL sat_drain_timeout busy still high"); end
        tests++; if (of_count !== 8'd255) begin fails++; $display("FAIL sat_of_count got=%0d exp=255", of_count); end
        res_ready = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        cyc = 4'd0;
        rst = 1'b1; rst3 = 1'b1;
        cmd_valid = 1'b0; cmd_m = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0; res_ready = 1'b0;
        l3_cmd_valid = 1'b0; l3_cmd_m = '0; l3_cmd_a = '0; l3_cmd_b = '0; l3_cmd_cin = 1'b0; l3_res_ready = 1'b0;
        test_reset();
        test_single_add();
        test_backpressure();
        test_reserved();
        test_latency();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
